// File: rtl/multi_mode_counter_pkg.sv
// Shared definitions for multi_mode_counter: the sequence-select encodings
// and the 2-bit mode type used by the top block.
package multi_mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_GRAY    = 2'b10,
        MODE_JOHNSON = 2'b11
    } mode_t;

    // Mode the counter returns to out of reset.
    localparam mode_t MODE_RESET = MODE_UP;

endpackage : multi_mode_counter_pkg

// File: rtl/multi_mode_counter_bin2gray.sv
// bin2gray: purely combinational binary-to-reflected-Gray converter.
// gray[i] = bin[i] ^ bin[i+1]; the MSB passes straight through.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // MSB of a reflected Gray code equals the binary MSB.
    assign gray[WIDTH-1] = bin[WIDTH-1];

    genvar gi;
    generate
        // Each lower Gray bit is the XOR of adjacent binary bits.
        for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_xor
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule : bin2gray

// File: rtl/multi_mode_counter.sv
// multi_mode_counter: WIDTH-bit counter with run-time selectable sequence
// (binary up, binary down, Gray, Johnson), synchronous load, count enable
// and a terminal-count flag.
// Optional build macro: MULTI_MODE_COUNTER_SATURATE_EN -- when defined the
// up/down/Gray modes stop at their terminal value instead of wrapping;
// Johnson mode always wraps.
module multi_mode_counter
    import multi_mode_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] x,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] JOHN_TC  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;
    mode_t            mode_reg;
    mode_t            mode_sel;
    logic [WIDTH-1:0] terminal_value;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] gray_value;
    logic             mode_match;
    logic             at_terminal;
    logic             hold_at_terminal;

    assign mode_sel   = mode_t'(mode);
    assign mode_match = (mode_sel == mode_reg);

    // Terminal value of the currently active sequence (last state before wrap).
    always_comb begin
        terminal_value = ALL_ONES;
        case (mode_reg)
            MODE_UP:      terminal_value = ALL_ONES;
            MODE_DOWN:    terminal_value = '0;
            MODE_GRAY:    terminal_value = ALL_ONES;
            MODE_JOHNSON: terminal_value = JOHN_TC;
            default:      terminal_value = ALL_ONES;
        endcase
    end

    assign at_terminal = (state_reg == terminal_value);

    // Next state of one enabled step; Gray mode counts in binary internally.
    always_comb begin
        step_value = state_reg;
        case (mode_reg)
            MODE_UP:      step_value = state_reg + ONE;
            MODE_DOWN:    step_value = state_reg - ONE;
            MODE_GRAY:    step_value = state_reg + ONE;
            MODE_JOHNSON: step_value = {state_reg[WIDTH-2:0], ~state_reg[WIDTH-1]};
            default:      step_value = state_reg;
        endcase
    end

`ifdef MULTI_MODE_COUNTER_SATURATE_EN
    // Binary-style sequences park on their terminal value; Johnson keeps cycling.
    assign hold_at_terminal = at_terminal && (mode_reg != MODE_JOHNSON);
`else
    assign hold_at_terminal = 1'b0;
`endif

    // Update priority below reset: mode change restart, then load, then step.
    always_comb begin
        state_next = state_reg;
        if (!mode_match) begin
            state_next = '0;
        end else if (load) begin
            state_next = load_value;
        end else if (enable && !hold_at_terminal) begin
            state_next = step_value;
        end
    end

    // State and active-mode registers; reset overrides everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= '0;
            mode_reg  <= MODE_RESET;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_sel;
        end
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (state_reg),
        .gray (gray_value)
    );

    assign x  = (mode_reg == MODE_GRAY) ? gray_value : state_reg;
    assign tc = enable & ~load & mode_match & at_terminal;

endmodule : multi_mode_counter

// File: tb/tb_multi_mode_counter.sv
// Directed testbench for multi_mode_counter (WIDTH = 4, 50 ns clock).
// Expected sequences are hand-written tables or simple closed forms.
// Build with MULTI_MODE_COUNTER_SATURATE_EN to exercise the saturating variant.
module tb_multi_mode_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic [1:0] mode;
    logic [3:0] x;
    logic       tc;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] gray_tbl [17] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9,
                                  4'd8, 4'd0};
    logic [3:0] john_tbl [11] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12,
                                  4'd8, 4'd0, 4'd1, 4'd3};

    multi_mode_counter #(
        .WIDTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .x          (x),
        .tc         (tc)
    );

    always #25 clock = ~clock;

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Reset, then one idle edge so the requested mode becomes active at x = 0.
    task automatic restart(input logic [1:0] m);
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = 4'd0; mode = m;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'd9; mode = 2'b11;
        tick();
        tick();
        reset = 1'b0; enable = 1'b0; load = 1'b0; mode = 2'b00;
        #1;
        tests_run++;
        if (x !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_x: x=%0d expected 0", x);
        end
        tests_run++;
        if (tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tc: tc=%0b expected 0", tc);
        end
        $display("[TB] reset: x=%0d tc=%0b", x, tc);
    endtask

    task automatic test_up();
        logic [3:0] exp_x;
        restart(2'b00);
        enable = 1'b1;
        #1;
        for (int i = 0; i < 18; i++) begin
`ifdef MULTI_MODE_COUNTER_SATURATE_EN
            exp_x = (i > 15) ? 4'd15 : 4'(i);
`else
            exp_x = 4'(i % 16);
`endif
            tests_run++;
            if (x !== exp_x) begin
                tests_failed++;
                $display("FAIL up_x[%0d]: x=%0d expected %0d", i, x, exp_x);
            end
            tests_run++;
            if (tc !== (exp_x == 4'd15)) begin
                tests_failed++;
                $display("FAIL up_tc[%0d]: tc=%0b expected %0b", i, tc, exp_x == 4'd15);
            end
            $display("[TB] up step %0d: x=%0d tc=%0b", i, x, tc);
            tick();
        end
    endtask

    task automatic test_down();
        logic [3:0] exp_x;
        restart(2'b01);
        enable = 1'b1;
        #1;
        for (int i = 0; i < 18; i++) begin
`ifdef MULTI_MODE_COUNTER_SATURATE_EN
            exp_x = 4'd0;
`else
            exp_x = 4'((16 - i) % 16);
`endif
            tests_run++;
            if (x !== exp_x) begin
                tests_failed++;
                $display("FAIL down_x[%0d]: x=%0d expected %0d", i, x, exp_x);
            end
            tests_run++;
            if (tc !== (exp_x == 4'd0)) begin
                tests_failed++;
                $display("FAIL down_tc[%0d]: tc=%0b expected %0b", i, tc, exp_x == 4'd0);
            end
            $display("[TB] down step %0d: x=%0d tc=%0b", i, x, tc);
            tick();
        end
    endtask

    task automatic test_gray();
        logic [3:0] exp_x;
        logic [3:0] prev_x;
        logic       exp_tc;
        restart(2'b10);
        enable = 1'b1;
        #1;
        prev_x = 4'd0;
        for (int i = 0; i < 17; i++) begin
`ifdef MULTI_MODE_COUNTER_SATURATE_EN
            exp_x  = (i > 15) ? 4'd8 : gray_tbl[i];
            exp_tc = (i >= 15);
`else
            exp_x  = gray_tbl[i];
            exp_tc = (i == 15);
`endif
            tests_run++;
            if (x !== exp_x) begin
                tests_failed++;
                $display("FAIL gray_x[%0d]: x=%0d expected %0d", i, x, exp_x);
            end
            tests_run++;
            if (tc !== exp_tc) begin
                tests_failed++;
                $display("FAIL gray_tc[%0d]: tc=%0b expected %0b", i, tc, exp_tc);
            end
            if (i >= 1 && i <= 15) begin
                tests_run++;
                if ($countones(x ^ prev_x) != 1) begin
                    tests_failed++;
                    $display("FAIL gray_onebit[%0d]: x=%0d prev=%0d expected one bit change",
                             i, x, prev_x);
                end
            end
            $display("[TB] gray step %0d: x=%0d tc=%0b", i, x, tc);
            prev_x = x;
            tick();
        end
    endtask

    task automatic test_johnson();
        restart(2'b11);
        enable = 1'b1;
        #1;
        for (int i = 0; i < 11; i++) begin
            tests_run++;
            if (x !== john_tbl[i]) begin
                tests_failed++;
                $display("FAIL john_x[%0d]: x=%0d expected %0d", i, x, john_tbl[i]);
            end
            tests_run++;
            if (tc !== (john_tbl[i] == 4'd8)) begin
                tests_failed++;
                $display("FAIL john_tc[%0d]: tc=%0b expected %0b", i, tc, john_tbl[i] == 4'd8);
            end
            $display("[TB] johnson step %0d: x=%0d tc=%0b", i, x, tc);
            if (i < 10) tick();
        end
        // x is 3 here; switch to up mode mid-sequence.
        mode = 2'b00;
        tick();
        tests_run++;
        if (x !== 4'd0) begin
            tests_failed++;
            $display("FAIL john_switch_restart: x=%0d expected 0", x);
        end
        tick();
        tests_run++;
        if (x !== 4'd1) begin
            tests_failed++;
            $display("FAIL john_switch_step1: x=%0d expected 1", x);
        end
        tick();
        tests_run++;
        if (x !== 4'd2) begin
            tests_failed++;
            $display("FAIL john_switch_step2: x=%0d expected 2", x);
        end
        $display("[TB] johnson->up switch: x=%0d", x);

        // Illegal pattern 0101 is not corrected: 0101 -> 1011 -> 0110.
        restart(2'b11);
        load = 1'b1; load_value = 4'd5;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        tests_run++;
        if (x !== 4'd11) begin
            tests_failed++;
            $display("FAIL john_illegal_1: x=%0d expected 11", x);
        end
        tick();
        tests_run++;
        if (x !== 4'd6) begin
            tests_failed++;
            $display("FAIL john_illegal_2: x=%0d expected 6", x);
        end
        $display("[TB] johnson illegal pattern: x=%0d", x);
    endtask

    task automatic test_mode_change();
        // At up-mode terminal, a pending mode change must mask tc and restart.
        restart(2'b00);
        load = 1'b1; load_value = 4'd15;
        tick();
        load = 1'b0; enable = 1'b1; mode = 2'b01;
        #1;
        tests_run++;
        if (tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL modechg_tc: tc=%0b expected 0", tc);
        end
        tick();
        tests_run++;
        if (x !== 4'd0) begin
            tests_failed++;
            $display("FAIL modechg_x: x=%0d expected 0", x);
        end
        $display("[TB] mode change at terminal: x=%0d", x);
    endtask

    task automatic test_load_reset();
        restart(2'b00);
        load = 1'b1; load_value = 4'd9;
        tick();
        tests_run++;
        if (x !== 4'd9) begin
            tests_failed++;
            $display("FAIL load_9: x=%0d expected 9", x);
        end
        reset = 1'b1; load_value = 4'd5; enable = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (x !== 4'd0) begin
            tests_failed++;
            $display("FAIL load_with_reset: x=%0d expected 0", x);
        end
        load_value = 4'd9; enable = 1'b0;
        tick();
        load_value = 4'd5; enable = 1'b1;
        tick();
        tests_run++;
        if (x !== 4'd5) begin
            tests_failed++;
            $display("FAIL load_5: x=%0d expected 5", x);
        end
        load = 1'b0;
        tick();
        tests_run++;
        if (x !== 4'd6) begin
            tests_failed++;
            $display("FAIL load_then_count: x=%0d expected 6", x);
        end
        // Load at the terminal value: load masks tc, then tc follows enable.
        load = 1'b1; load_value = 4'd15;
        #1;
        tests_run++;
        if (tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_masks_tc: tc=%0b expected 0", tc);
        end
        tick();
        load = 1'b0;
        #1;
        tests_run++;
        if (tc !== 1'b1) begin
            tests_failed++;
            $display("FAIL terminal_tc: tc=%0b expected 1", tc);
        end
        enable = 1'b0;
        #1;
        tests_run++;
        if (tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL disabled_tc: tc=%0b expected 0", tc);
        end
        tick();
        tests_run++;
        if (x !== 4'd15) begin
            tests_failed++;
            $display("FAIL disabled_hold: x=%0d expected 15", x);
        end
        $display("[TB] load/reset priority: x=%0d tc=%0b", x, tc);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_x;
        restart(2'b00);
        load = 1'b1; load_value = 4'd3;
        tick();
        load = 1'b0;
        exp_x = 4'd3;
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            tick();
            if (i % 2 == 0) exp_x = exp_x + 4'd1;
            tests_run++;
            if (x !== exp_x) begin
                tests_failed++;
                $display("FAIL toggle_x[%0d]: x=%0d expected %0d", i, x, exp_x);
            end
            $display("[TB] toggle step %0d: enable=%0b x=%0d", i, enable, x);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = 4'd0; mode = 2'b00;
        test_reset();
        test_up();
        test_down();
        test_gray();
        test_johnson();
        test_mode_change();
        test_load_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_multi_mode_counter
